// File: rtl/keypad_pkg.sv
// Shared types, key codes and the keypad matrix map for the 4x4 hex keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_NEWPW = 4'hA;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Index is {row, col}; col0 is the column driven by keyPad_column[0].
    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] row_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and single-cycle key strobes.
// Define KEYPAD_REPEAT_EN to re-pulse the held key's strobe every REPEAT_CYCLES.
//
// state    | meaning
// SCAN     | drive one column for SCAN_DWELL cycles, then sample rows
// DEBOUNCE | single-row press seen; wait for DEBOUNCE_CYCLES stable cycles
// HELD     | key accepted; column frozen until rows idle for DEBOUNCE_CYCLES
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DWELL      = 100_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keyPad_row,
    output logic [3:0] keyPad_column,
    output logic [3:0] digit,
    output logic       valid,
    output logic       enter,
    output logic       newPassword
);

    localparam int DW = $clog2(SCAN_DWELL + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_TC = DW'(SCAN_DWELL - 1);
    localparam logic [BW-1:0] DEB_TC   = BW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DWELL < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("keypad_scanner: cycle parameters must be at least 1");
    end

    logic [3:0]    row_s;
    kp_state_t     state_q;
    logic [3:0]    col_q;
    logic [DW-1:0] dwell_q;
    logic [BW-1:0] deb_q;
    logic [BW-1:0] rel_q;
    logic [3:0]    row_lat_q;
    logic [1:0]    row_idx_q;
    logic [1:0]    col_idx_q;
    logic [3:0]    digit_q;
    logic          valid_q;
    logic          enter_q;
    logic          newpw_q;
    logic [3:0]    key_code;
    logic          release_done;

    keypad_row_sync u_row_sync (
        .clk   (clk),
        .rst_n (reset),
        .row_i (keyPad_row),
        .row_o (row_s)
    );

    assign key_code     = keymap(row_idx_q, col_idx_q);
    assign release_done = (row_s == 4'hF) && (rel_q == DEB_TC);

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_TC = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            col_q     <= COL_FIRST;
            dwell_q   <= '0;
            deb_q     <= '0;
            rel_q     <= '0;
            row_lat_q <= 4'hF;
            row_idx_q <= 2'd0;
            col_idx_q <= 2'd0;
            digit_q   <= 4'h0;
            valid_q   <= 1'b0;
            enter_q   <= 1'b0;
            newpw_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            enter_q <= 1'b0;
            newpw_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_TC) begin
                        dwell_q <= '0;
                        if ($onehot(~row_s)) begin
                            row_lat_q <= row_s;
                            row_idx_q <= onehot_idx(~row_s);
                            col_idx_q <= onehot_idx(~col_q);
                            deb_q     <= '0;
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_q <= {col_q[2:0], col_q[3]};
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s != row_lat_q) begin
                        dwell_q <= '0;
                        state_q <= SCAN;
                    end else if (deb_q == DEB_TC) begin
                        digit_q <= key_code;
                        valid_q <= (key_code != KEY_ENTER) && (key_code != KEY_NEWPW);
                        enter_q <= (key_code == KEY_ENTER);
                        newpw_q <= (key_code == KEY_NEWPW);
                        rel_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_q   <= '0;
`endif
                        state_q <= HELD;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                HELD: begin
                    // Any low row, including a second key, restarts the release window.
                    if (release_done) begin
                        rel_q   <= '0;
                        dwell_q <= '0;
                        col_q   <= {col_q[2:0], col_q[3]};
                        state_q <= SCAN;
                    end else if (row_s == 4'hF) begin
                        rel_q <= rel_q + 1'b1;
                    end else begin
                        rel_q <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (release_done) begin
                        rep_q <= '0;
                    end else if (rep_q == REP_TC) begin
                        rep_q   <= '0;
                        valid_q <= (digit_q != KEY_ENTER) && (digit_q != KEY_NEWPW);
                        enter_q <= (digit_q == KEY_ENTER);
                        newpw_q <= (digit_q == KEY_NEWPW);
                    end else begin
                        rep_q <= rep_q + 1'b1;
                    end
`endif
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign keyPad_column = col_q;
    assign digit         = digit_q;
    assign valid         = valid_q;
    assign enter         = enter_q;
    assign newPassword   = newpw_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a key-matrix model drives the rows, a monitor checks strobes.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  keyPad_row;
    logic [3:0]  keyPad_column;
    logic [3:0]  digit;
    logic        valid;
    logic        enter;
    logic        newPassword;
    logic [15:0] pressed = 16'h0;

    typedef struct {
        logic [2:0] strobes;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   strobe_cnt = 0;

    localparam logic [2:0] S_VALID = 3'b100;
    localparam logic [2:0] S_ENTER = 3'b010;
    localparam logic [2:0] S_NEWPW = 3'b001;

    keypad_scanner #(
        .SCAN_DWELL      (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .keyPad_row    (keyPad_row),
        .keyPad_column (keyPad_column),
        .digit         (digit),
        .valid         (valid),
        .enter         (enter),
        .newPassword   (newPassword)
    );

    always #5 clk = ~clk;

    // pressed bit index is row*4+col; a row reads low when a pressed key sits in a driven column.
    always_comb begin
        keyPad_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !keyPad_column[c]) keyPad_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (valid | enter | newPassword)) begin
            strobe_cnt++;
            check("strobe_onehot", $countones({valid, enter, newPassword}), 1);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got v/e/n=%b%b%b digit=%h, required no strobe",
                         valid, enter, newPassword, digit);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {valid, enter, newPassword}, e.strobes);
                check("strobe_digit", digit, e.code);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic [2:0] s, input logic [3:0] code);
        exp_t e;
        e.strobes = s;
        e.code    = code;
        exp_q.push_back(e);
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int start;
        int n;
        start = strobe_cnt;
        n = 0;
        while (strobe_cnt == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(strobe_cnt != start), 1);
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (keyPad_column !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, keyPad_column, target);
    endtask

    initial begin
        // 1: reset mid-run, then free-running scan
        tick(3);
        reset = 1'b1;
        tick(10);
        reset = 1'b0;
        #1;
        check("rst_column", keyPad_column, 4'b1110);
        check("rst_digit", digit, 4'h0);
        check("rst_strobes", {valid, enter, newPassword}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        check("scan_col0", keyPad_column, 4'b1110);
        tick(3);
        check("scan_col1", keyPad_column, 4'b1101);
        tick(4);
        check("scan_col2", keyPad_column, 4'b1011);

        // 2: key 5 (r1,c1) held stable, then released
        expect_strobe(S_VALID, 4'h5);
        pressed[1*4+1] = 1'b1;
        wait_strobe(200, "key5_accept");
        check("key5_digit", digit, 4'h5);
        check("key5_col_held", keyPad_column, 4'b1101);
        @(negedge clk);
        check("key5_strobe_1cycle", {valid, enter, newPassword}, 3'b000);
        tick(4);
        check("key5_col_frozen", keyPad_column, 4'b1101);
        pressed = 16'h0;
        tick(6);
        check("key5_col_release_window", keyPad_column, 4'b1101);
        tick(6);
        check("key5_col_after_release", keyPad_column, 4'b1011);

        // 3: key 5 bouncing every 3 cycles, never stable long enough
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[1*4+1] = ~pressed[1*4+1];
            tick(1);
        end
        pressed = 16'h0;
        tick(20);
        wait_col(4'b1110, 40, "bounce_scan_resumes");
        check("bounce_digit_kept", digit, 4'h5);

        // 4: E then A
        expect_strobe(S_ENTER, 4'hE);
        pressed[3*4+2] = 1'b1;
        wait_strobe(200, "keyE_accept");
        check("keyE_digit", digit, 4'hE);
        @(negedge clk);
        check("keyE_strobe_1cycle", {valid, enter, newPassword}, 3'b000);
        pressed = 16'h0;
        tick(20);
        expect_strobe(S_NEWPW, 4'hA);
        pressed[0*4+3] = 1'b1;
        wait_strobe(200, "keyA_accept");
        check("keyA_digit", digit, 4'hA);
        tick(1);
        pressed = 16'h0;
        tick(20);

        // 5: two rows low in col0 is rejected; then key 9 held long
        pressed[0*4+0] = 1'b1;
        pressed[2*4+0] = 1'b1;
        tick(10);
        wait_col(4'b0111, 40, "multirow_scan_continues");
        tick(20);
        check("multirow_digit_kept", digit, 4'hA);
        pressed = 16'h0;
        tick(20);
        expect_strobe(S_VALID, 4'h9);
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 4; i++) expect_strobe(S_VALID, 4'h9);
`endif
        pressed[2*4+2] = 1'b1;
        wait_strobe(200, "key9_accept");
        tick(85);
        pressed = 16'h0;
        tick(30);
        check("key9_digit", digit, 4'h9);

        // 6: reset while key 7 is held, released with key up
        expect_strobe(S_VALID, 4'h7);
        pressed[2*4+0] = 1'b1;
        wait_strobe(200, "key7_accept");
        tick(2);
        reset = 1'b0;
        #1;
        check("held_rst_digit", digit, 4'h0);
        check("held_rst_column", keyPad_column, 4'b1110);
        check("held_rst_strobes", {valid, enter, newPassword}, 3'b000);
        tick(3);
        pressed = 16'h0;
        tick(2);
        reset = 1'b1;
        tick(30);
        check("post_rst_digit", digit, 4'h0);
        wait_col(4'b1101, 20, "post_rst_scanning");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
